lcg_stream_checker: RTL and testbench
=====================================

Name: lcg_stream_checker

Overview:
- Receive-side checker for the 32-bit LCG random stream: next = state*MULTIPLIER + INCREMENT, mod 2^32.
- Takes sampled PRNG words, self-synchronises to the sequence, predicts each following word, and reports lock status and error counts.
- Sits downstream of the LCG generators in the PRNG test path as the on-chip stream integrity monitor.

Parameters:
- MULTIPLIER, 32'h3E8A91CF, LCG multiplier; must match the generator.
- INCREMENT, 32'hD4721B60, LCG increment; must match the generator.
- LOCK_COUNT, 4, consecutive correct predictions needed to declare lock (range 1..15).
- LOSS_COUNT, 3, consecutive mispredictions in LOCKED that drop lock (range 1..15).
- CNT_W, 16, width of the error and sample counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  in_data holds a stream word this cycle.
- in_data  in  32  received PRNG word.
- clear  in  1  synchronous clear of the counters.
- locked  out  1  FSM is in LOCKED.
- err_pulse  out  1  one-cycle pulse per misprediction while LOCKED.
- err_count  out  CNT_W  saturating count of LOCKED mispredictions.
- sample_count  out  CNT_W  saturating count of accepted in_valid words.
- expected  out  32  current prediction of the next word.

Behaviour:
- f(x) = low 32 bits of (x*MULTIPLIER) + INCREMENT; carries beyond bit 31 are discarded.
- Reset values: FSM state IDLE; locked=0; err_pulse=0; err_count=0; sample_count=0; expected=0; internal match/miss counters=0.
- All outputs are registered. Status for a word sampled at edge N is visible after edge N, i.e. one-cycle latency. in_valid=0 cycles leave all state unchanged and force err_pulse=0.
- IDLE:
  - On valid: expected<=f(in_data); match_cnt<=0; go to ACQ.
- ACQ:
  - Valid and in_data==expected: match_cnt++ and expected<=f(in_data).
  - If that match makes match_cnt==LOCK_COUNT, go to LOCKED and clear miss_cnt.
  - Valid and mismatch: reseed with expected<=f(in_data); match_cnt<=0; stay in ACQ; no error is counted.
- LOCKED:
  - Valid and match: expected<=f(in_data); miss_cnt<=0.
  - Valid and mismatch: err_pulse=1 for the next cycle; err_count++; miss_cnt++.
  - Flywheel on mismatch: expected<=f(expected), not f(in_data).
  - If miss_cnt reaches LOSS_COUNT: go to ACQ; expected<=f(in_data); match_cnt<=0; locked falls the next cycle.
- locked=1 exactly while the state is LOCKED.
- Counters saturate at all-ones and never wrap.
- clear=1: err_count and sample_count go to 0 next cycle. Clear wins over a simultaneous increment. FSM, expected, match_cnt and miss_cnt are unaffected.
- Asynchronous reset mid-stream aborts immediately to the reset values. The first valid word after rst release is treated as a seed.
- LOCK_COUNT=1: the first correct prediction in ACQ locks.

Optional Feature:
- Macro: LCG_CHK_DROP_TOL_EN.
- Defined, in LOCKED:
  - A mismatching word equal to f(expected) counts as a single dropped sample, not an error.
  - Response: expected<=f(in_data); miss_cnt<=0; err_pulse stays 0; new output drop_count (CNT_W, saturating, cleared by clear and reset) increments.
  - ACQ behaviour is unchanged.
- Undefined:
  - No drop_count port and no second predictor.
  - Any mismatch is an error, exactly as above.

Test Plan:
- Seed acquisition: reset, then feed a generator stream seeded 0x00000000; first word 0xD4721B60, rest from the golden model, one word per cycle.
  - After word 1, expected = f(0xD4721B60).
  - locked rises the cycle after word 5 (1 seed + LOCK_COUNT=4 matches).
  - err_count stays 0; sample_count=5.
- Single corruption while locked: flip bit 0 of one word.
  - err_pulse high for exactly one cycle; err_count=1; locked stays 1.
  - Next correct word matches via the flywheel; miss_cnt clears.
- Loss of lock: three consecutive garbage words (0xDEADBEEF).
  - err_count=3; locked falls after the third.
  - A fresh valid stream relocks after 1+4 words.
- Gaps and clear:
  - Insert in_valid=0 idle cycles mid-stream: no state change, no error.
  - Assert clear in the same cycle as an error: err_count=0 afterwards, locked unaffected.
- Saturation and reset: with CNT_W=4, force 20 mispredictions.
  - err_count holds 4'hF.
  - Assert rst mid-stream: all outputs return to 0 asynchronously, then reacquire from a new seed.
- LCG_CHK_DROP_TOL_EN defined: while locked, omit one word from the stream.
  - drop_count=1, err_count=0, err_pulse never asserts, locked stays 1.
  - Omitting two consecutive words is counted as an error.

Source files
------------

// File: rtl/lcg_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : lcg_stream_checker
// Description : Receive-side integrity checker for a 32-bit LCG stream
//               (next = state*MULTIPLIER + INCREMENT mod 2^32). Seeds from
//               the first word, predicts each following word, declares lock
//               after LOCK_COUNT consecutive hits and drops it after
//               LOSS_COUNT consecutive misses. All outputs are registered.
//               Optional macro LCG_CHK_DROP_TOL_EN: while locked, a word
//               equal to the prediction after next is counted as one
//               dropped sample (drop_count) instead of an error.
// Revision    : 1.0 - initial release
// ============================================================================
module lcg_stream_checker #(
    parameter logic [31:0] MULTIPLIER = 32'h3E8A91CF,
    parameter logic [31:0] INCREMENT  = 32'hD4721B60,
    parameter int          LOCK_COUNT = 4,
    parameter int          LOSS_COUNT = 3,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] sample_count,
`ifdef LCG_CHK_DROP_TOL_EN
    output logic [CNT_W-1:0] drop_count,
`endif
    output logic [31:0]      expected
);

    localparam logic [3:0]       c_LOCK_CNT = 4'(LOCK_COUNT);
    localparam logic [3:0]       c_LOSS_CNT = 4'(LOSS_COUNT);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_match_cnt;
    logic [3:0] r_miss_cnt;

    state_t      w_state_nxt;
    logic [31:0] w_exp_nxt;
    logic [3:0]  w_match_nxt;
    logic [3:0]  w_miss_nxt;
    logic [3:0]  w_match_inc;
    logic [3:0]  w_miss_inc;
    logic [31:0] w_pred_in;
    logic [31:0] w_pred_fly;
    logic        w_err_hit;
`ifdef LCG_CHK_DROP_TOL_EN
    logic        w_drop_hit;
`endif

    // One LCG step; the product is truncated to 32 bits before the add.
    function automatic logic [31:0] lcg_next(input logic [31:0] x);
        logic [31:0] prod;
        prod     = x * MULTIPLIER;
        lcg_next = prod + INCREMENT;
    endfunction

    // Next-state, prediction and event decode for one accepted word.
    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = expected;
        w_match_nxt = r_match_cnt;
        w_miss_nxt  = r_miss_cnt;
        w_err_hit   = 1'b0;
`ifdef LCG_CHK_DROP_TOL_EN
        w_drop_hit  = 1'b0;
`endif
        w_pred_in   = lcg_next(in_data);
        w_pred_fly  = lcg_next(expected);
        w_match_inc = r_match_cnt + 4'd1;
        w_miss_inc  = r_miss_cnt + 4'd1;
        if (in_valid) begin
            case (r_state)
                ST_IDLE: begin
                    w_exp_nxt   = w_pred_in;
                    w_match_nxt = 4'd0;
                    w_state_nxt = ST_ACQ;
                end
                ST_ACQ: begin
                    w_exp_nxt = w_pred_in;
                    if (in_data == expected) begin
                        w_match_nxt = w_match_inc;
                        if (w_match_inc == c_LOCK_CNT) begin
                            w_state_nxt = ST_LOCKED;
                            w_miss_nxt  = 4'd0;
                        end
                    end else begin
                        // Mismatch while acquiring simply reseeds.
                        w_match_nxt = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (in_data == expected) begin
                        w_exp_nxt  = w_pred_in;
                        w_miss_nxt = 4'd0;
                    end
`ifdef LCG_CHK_DROP_TOL_EN
                    else if (in_data == w_pred_fly) begin
                        // Exactly one word missing from the stream.
                        w_drop_hit = 1'b1;
                        w_exp_nxt  = w_pred_in;
                        w_miss_nxt = 4'd0;
                    end
`endif
                    else begin
                        // Flywheel: keep advancing our own prediction so a
                        // single corrupted word does not derail tracking.
                        w_err_hit  = 1'b1;
                        w_miss_nxt = w_miss_inc;
                        w_exp_nxt  = w_pred_fly;
                        if (w_miss_inc == c_LOSS_CNT) begin
                            w_state_nxt = ST_ACQ;
                            w_exp_nxt   = w_pred_in;
                            w_match_nxt = 4'd0;
                            w_miss_nxt  = 4'd0;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM, prediction and match/miss counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            expected    <= 32'd0;
            r_match_cnt <= 4'd0;
            r_miss_cnt  <= 4'd0;
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            expected    <= w_exp_nxt;
            r_match_cnt <= w_match_nxt;
            r_miss_cnt  <= w_miss_nxt;
            locked      <= (w_state_nxt == ST_LOCKED);
            err_pulse   <= w_err_hit;
        end
    end

    // Saturating statistics counters; clear takes priority over increments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count    <= '0;
            sample_count <= '0;
        end else if (clear) begin
            err_count    <= '0;
            sample_count <= '0;
        end else begin
            if (w_err_hit && (err_count != c_CNT_MAX)) begin
                err_count <= err_count + 1'b1;
            end
            if (in_valid && (sample_count != c_CNT_MAX)) begin
                sample_count <= sample_count + 1'b1;
            end
        end
    end

`ifdef LCG_CHK_DROP_TOL_EN
    // Saturating count of single dropped samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_count <= '0;
        end else if (clear) begin
            drop_count <= '0;
        end else if (w_drop_hit && (drop_count != c_CNT_MAX)) begin
            drop_count <= drop_count + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lcg_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcg_stream_checker
// Description : Scoreboard bench for lcg_stream_checker. The driver pushes the
//               hand-derived response for each vector; a negedge monitor pops
//               and compares. A second instance (CNT_W=4, LOCK_COUNT=1) covers
//               saturation. Honours LCG_CHK_DROP_TOL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcg_stream_checker;

    localparam logic [31:0] c_MULT = 32'h3E8A91CF;
    localparam logic [31:0] c_INC  = 32'hD4721B60;
    localparam logic [31:0] c_BAD  = 32'hDEADBEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic        rst, in_valid, clear;
    logic [31:0] in_data;
    logic        locked, err_pulse;
    logic [15:0] err_count, sample_count;
    logic [31:0] expected;
`ifdef LCG_CHK_DROP_TOL_EN
    logic [15:0] drop_count;
    logic [3:0]  s_drop;
`endif

    // Saturation instance signals
    logic        s_rst, s_valid, s_clear;
    logic [31:0] s_data;
    logic        s_locked, s_pulse;
    logic [3:0]  s_err, s_smp;
    logic [31:0] s_exp;

    lcg_stream_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .clear(clear), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count), .sample_count(sample_count),
`ifdef LCG_CHK_DROP_TOL_EN
        .drop_count(drop_count),
`endif
        .expected(expected)
    );

    lcg_stream_checker #(.LOCK_COUNT(1), .LOSS_COUNT(3), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(s_rst), .in_valid(s_valid), .in_data(s_data),
        .clear(s_clear), .locked(s_locked), .err_pulse(s_pulse),
        .err_count(s_err), .sample_count(s_smp),
`ifdef LCG_CHK_DROP_TOL_EN
        .drop_count(s_drop),
`endif
        .expected(s_exp)
    );

    typedef struct packed {
        logic        lock;
        logic        pulse;
        logic [15:0] err;
        logic [15:0] smp;
        logic [31:0] exp;
        logic [15:0] drop;
        logic [31:0] id;
    } item_t;

    item_t sb[$];
    item_t m_item;
    int    n_vec  = 0;
    int    n_miss = 0;
    int    vid    = 1;
    logic [15:0] e_drop = 16'd0;
    logic [31:0] gen, p, sg;

    function automatic logic [31:0] f(input logic [31:0] x);
        logic [31:0] prod;
        prod = x * c_MULT;
        return prod + c_INC;
    endfunction

    task automatic check(input string name, input int id,
                         input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s (vec %0d): got %h required %h", name, id, act, req);
        end
    endtask

    // Drive one vector and queue the response required after its edge.
    task automatic apply(input logic v, input logic [31:0] d, input logic clr,
                         input logic lk, input logic pl, input logic [15:0] er,
                         input logic [15:0] sm, input logic [31:0] ex);
        item_t it;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        clear    = clr;
        @(posedge clk);
        it.lock = lk; it.pulse = pl; it.err = er; it.smp = sm;
        it.exp = ex; it.drop = e_drop; it.id = vid;
        sb.push_back(it);
        vid++;
    endtask

    task automatic s_apply(input logic v, input logic [31:0] d, input logic clr);
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        s_clear = clr;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare registered outputs mid-cycle against the scoreboard.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            m_item = sb.pop_front();
            check("locked", m_item.id, 32'(locked), 32'(m_item.lock));
            check("err_pulse", m_item.id, 32'(err_pulse), 32'(m_item.pulse));
            check("err_count", m_item.id, 32'(err_count), 32'(m_item.err));
            check("sample_count", m_item.id, 32'(sample_count), 32'(m_item.smp));
            check("expected", m_item.id, expected, m_item.exp);
`ifdef LCG_CHK_DROP_TOL_EN
            check("drop_count", m_item.id, 32'(drop_count), 32'(m_item.drop));
`endif
        end
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = 32'd0; clear = 1'b0;
        s_rst = 1'b0; s_valid = 1'b0; s_data = 32'd0; s_clear = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_locked", 0, 32'(locked), 32'd0);
        check("rst_pulse", 0, 32'(err_pulse), 32'd0);
        check("rst_err", 0, 32'(err_count), 32'd0);
        check("rst_smp", 0, 32'(sample_count), 32'd0);
        check("rst_exp", 0, expected, 32'd0);
        @(negedge clk);
        rst = 1'b1; s_rst = 1'b1;

        // Seed acquisition, stream seeded 0: first word is f(0)
        gen = 32'hD4721B60;
        apply(1'b1, gen, 1'b0, 1'b0, 1'b0, 16'd0, 16'd1, f(gen));
        for (int i = 2; i <= 5; i++) begin
            if (i == 4) begin
                repeat (2) apply(1'b0, 32'h0BADF00D, 1'b0, 1'b0, 1'b0, 16'd0, 16'd3, f(gen));
            end
            gen = f(gen);
            apply(1'b1, gen, 1'b0, (i == 5), 1'b0, 16'd0, 16'(i), f(gen));
        end

        // Single corruption, then flywheel recovery
        gen = f(gen);
        apply(1'b1, gen ^ 32'h1, 1'b0, 1'b1, 1'b1, 16'd1, 16'd6, f(gen));
        gen = f(gen);
        apply(1'b1, gen, 1'b0, 1'b1, 1'b0, 16'd1, 16'd7, f(gen));
        apply(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 16'd1, 16'd7, f(gen));

        // Clear in the same cycle as an error
        gen = f(gen);
        apply(1'b1, gen ^ 32'h80000000, 1'b1, 1'b1, 1'b1, 16'd0, 16'd0, f(gen));
        gen = f(gen);
        apply(1'b1, gen, 1'b0, 1'b1, 1'b0, 16'd0, 16'd1, f(gen));

        // Loss of lock after three consecutive garbage words
        p = f(gen);
        apply(1'b1, c_BAD, 1'b0, 1'b1, 1'b1, 16'd1, 16'd2, f(p));
        p = f(p);
        apply(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 16'd1, 16'd2, p);
        apply(1'b1, c_BAD, 1'b0, 1'b1, 1'b1, 16'd2, 16'd3, f(p));
        apply(1'b1, c_BAD, 1'b0, 1'b0, 1'b1, 16'd3, 16'd4, f(c_BAD));

        // Relock on a fresh stream: one reseed plus four matches
        gen = 32'h12345678;
        apply(1'b1, gen, 1'b0, 1'b0, 1'b0, 16'd3, 16'd5, f(gen));
        for (int i = 1; i <= 4; i++) begin
            gen = f(gen);
            apply(1'b1, gen, 1'b0, (i == 4), 1'b0, 16'd3, 16'(5 + i), f(gen));
        end

`ifdef LCG_CHK_DROP_TOL_EN
        // One omitted word is a drop; two omitted words are an error
        gen = f(f(gen));
        e_drop = 16'd1;
        apply(1'b1, gen, 1'b0, 1'b1, 1'b0, 16'd3, 16'd10, f(gen));
        p = f(gen);
        gen = f(f(f(gen)));
        apply(1'b1, gen, 1'b0, 1'b1, 1'b1, 16'd4, 16'd11, f(p));
`endif

        // Asynchronous reset mid-stream
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_locked", -1, 32'(locked), 32'd0);
        check("arst_pulse", -1, 32'(err_pulse), 32'd0);
        check("arst_err", -1, 32'(err_count), 32'd0);
        check("arst_smp", -1, 32'(sample_count), 32'd0);
        check("arst_exp", -1, expected, 32'd0);
`ifdef LCG_CHK_DROP_TOL_EN
        check("arst_drop", -1, 32'(drop_count), 32'd0);
`endif
        in_valid = 1'b0;
        e_drop = 16'd0;
        @(negedge clk);
        rst = 1'b1;

        // Reacquire from a new seed
        gen = 32'hCAFEF00D;
        apply(1'b1, gen, 1'b0, 1'b0, 1'b0, 16'd0, 16'd1, f(gen));
        for (int i = 2; i <= 5; i++) begin
            gen = f(gen);
            apply(1'b1, gen, 1'b0, (i == 5), 1'b0, 16'd0, 16'(i), f(gen));
        end
        @(negedge clk);
        in_valid = 1'b0;

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
        check("sb_drain", -2, 32'(sb.size()), 32'd0);

        // Saturation instance: LOCK_COUNT=1 locks on the first hit
        sg = 32'h00000005;
        s_apply(1'b1, sg, 1'b0);
        check("sat_seed_locked", -3, 32'(s_locked), 32'd0);
        sg = f(sg);
        s_apply(1'b1, sg, 1'b0);
        check("sat_lock1", -3, 32'(s_locked), 32'd1);
        check("sat_exp", -3, s_exp, f(sg));
        for (int k = 0; k < 20; k++) begin
            sg = f(sg);
            s_apply(1'b1, sg ^ 32'hFFFF0000, 1'b0);
            sg = f(sg);
            s_apply(1'b1, sg, 1'b0);
        end
        check("sat_err", -3, 32'(s_err), 32'hF);
        check("sat_smp", -3, 32'(s_smp), 32'hF);
        check("sat_locked", -3, 32'(s_locked), 32'd1);
        check("sat_exp2", -3, s_exp, f(sg));
        s_apply(1'b0, 32'd0, 1'b1);
        check("sat_clr_err", -3, 32'(s_err), 32'd0);
        check("sat_clr_smp", -3, 32'(s_smp), 32'd0);
        check("sat_clr_locked", -3, 32'(s_locked), 32'd1);
        s_clear = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
